// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle control FSM for the RISC-V core. Each instruction is walked
// through fetch / decode / execute / memory / writeback over several clocks so
// the ALU, the shared instruction/data memory port and the register file are
// reused within one instruction. Memory requests wait on i_mem_ready, a
// watchdog traps a request that never completes, and unsupported instructions
// raise a one-cycle o_illegal pulse in DECODE.
//
// Optional feature macro: BRANCH_EXT_EN
//   defined   : branch funct3 000 (beq, taken on zero) and 001 (bne, taken on
//               non-zero) are legal; other branch funct3 values are illegal.
//   undefined : only funct3 000 (beq) is a legal branch.
//
// Parameters
//   ALUCTRL_W       width of o_alucrtl (3-bit codes zero-extended)
//   TIMEOUT_CYCLES  wait cycles on one memory request before FAULT; 0 disables
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_op, i_funct3,
//   i_funct7b5           instruction fields from the instruction register
//   i_zero               ALU zero flag
//   i_mem_ready          memory completes the current request this cycle
//   o_mem_req/o_memwrite memory request strobe and its write qualifier
//   o_adrsrc             memory address select (0 PC, 1 ALUOut)
//   o_irwrite, o_pcwrite,
//   o_regwrite           register load enables
//   o_resultsrc, o_alusrca, o_alusrcb, o_immsrc, o_alucrtl
//                        datapath mux selects and ALU operation
//   o_illegal            one-cycle pulse on an unsupported instruction
//   o_fault              watchdog fault, held until reset
//   o_state              current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int ALUCTRL_W      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [6:0]           i_op,
  input  logic [2:0]           i_funct3,
  input  logic                 i_funct7b5,
  input  logic                 i_zero,
  input  logic                 i_mem_ready,
  output logic                 o_mem_req,
  output logic                 o_memwrite,
  output logic                 o_adrsrc,
  output logic                 o_irwrite,
  output logic                 o_pcwrite,
  output logic                 o_regwrite,
  output logic [1:0]           o_resultsrc,
  output logic [1:0]           o_alusrca,
  output logic [1:0]           o_alusrcb,
  output logic [1:0]           o_immsrc,
  output logic [ALUCTRL_W-1:0] o_alucrtl,
  output logic                 o_illegal,
  output logic                 o_fault,
  output logic [3:0]           o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  // The counter only has to hold values up to TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             req_state;
  logic             timeout_hit;
  logic             branch_legal;
  logic             branch_taken;

  // ALU operation: aluop 00 add, 01 sub, 10 decode from funct fields.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [2:0] funct3,
                                            input logic       sub_bit);
    logic [2:0] ctrl;
    ctrl = 3'b000;
    case (aluop)
      2'b01:   ctrl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ctrl = sub_bit ? 3'b001 : 3'b000;
          3'b010:  ctrl = 3'b101;
          3'b110:  ctrl = 3'b011;
          3'b111:  ctrl = 3'b010;
          default: ctrl = 3'b000;
        endcase
      end
      default: ctrl = 3'b000;
    endcase
    return ctrl;
  endfunction

`ifdef BRANCH_EXT_EN
  assign branch_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001);
  assign branch_taken = i_funct3[0] ? !i_zero : i_zero;
`else
  assign branch_legal = (i_funct3 == 3'b000);
  assign branch_taken = i_zero;
`endif

  assign req_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                     (state == S_MEMWRITE);

  // Ready takes priority: a request completing on the last allowed cycle is
  // not a timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && req_state && !i_mem_ready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register and watchdog counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state logic.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state    = state;
    wait_cnt_next = '0;
    if (TIMEOUT_CYCLES != 0 && req_state && !i_mem_ready && !timeout_hit)
      wait_cnt_next = wait_cnt + 1'b1;

    case (state)
      S_FETCH: begin
        if (i_mem_ready)      next_state = S_DECODE;
        else if (timeout_hit) next_state = S_FAULT;
      end
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_JAL:       next_state = S_JAL;
          OP_BR:        next_state = branch_legal ? S_BEQ : S_FETCH;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (i_mem_ready)      next_state = S_MEMWB;
        else if (timeout_hit) next_state = S_FAULT;
      end
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: begin
        if (i_mem_ready)      next_state = S_FETCH;
        else if (timeout_hit) next_state = S_FAULT;
      end
      S_EXECR, S_EXECI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_BEQ:      next_state = S_FETCH;
      S_FAULT:    next_state = S_FAULT;
      default:    next_state = S_FETCH;
    endcase
  end

  // Output logic. Everything is forced low while reset is asserted so an
  // abandoned instruction cannot issue a strobe in the reset cycle.
  always_comb begin
    logic [1:0] aluop;
    aluop       = 2'b00;
    o_mem_req   = 1'b0;
    o_memwrite  = 1'b0;
    o_adrsrc    = 1'b0;
    o_irwrite   = 1'b0;
    o_pcwrite   = 1'b0;
    o_regwrite  = 1'b0;
    o_resultsrc = 2'b00;
    o_alusrca   = 2'b00;
    o_alusrcb   = 2'b00;
    o_immsrc    = 2'b00;
    o_illegal   = 1'b0;
    o_fault     = 1'b0;
    o_state     = 4'd0;

    if (!i_rst) begin
      o_state = state;

      case (i_op)
        OP_SW:   o_immsrc = 2'b01;
        OP_BR:   o_immsrc = 2'b10;
        OP_JAL:  o_immsrc = 2'b11;
        default: o_immsrc = 2'b00;
      endcase

      case (state)
        S_FETCH: begin
          o_mem_req   = 1'b1;
          o_alusrcb   = 2'b10;
          o_resultsrc = 2'b10;
          o_irwrite   = i_mem_ready;
          o_pcwrite   = i_mem_ready;
        end
        S_DECODE: begin
          o_alusrca = 2'b01;
          o_alusrcb = 2'b01;
          case (i_op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL: o_illegal = 1'b0;
            OP_BR:   o_illegal = !branch_legal;
            default: o_illegal = 1'b1;
          endcase
        end
        S_MEMADR: begin
          o_alusrca = 2'b10;
          o_alusrcb = 2'b01;
        end
        S_MEMREAD: begin
          o_mem_req = 1'b1;
          o_adrsrc  = 1'b1;
        end
        S_MEMWB: begin
          o_resultsrc = 2'b01;
          o_regwrite  = 1'b1;
        end
        S_MEMWRITE: begin
          o_mem_req  = 1'b1;
          o_memwrite = 1'b1;
          o_adrsrc   = 1'b1;
        end
        S_EXECR: begin
          o_alusrca = 2'b10;
          aluop     = 2'b10;
        end
        S_EXECI: begin
          o_alusrca = 2'b10;
          o_alusrcb = 2'b01;
          aluop     = 2'b10;
        end
        S_ALUWB: o_regwrite = 1'b1;
        S_JAL: begin
          o_alusrca = 2'b01;
          o_alusrcb = 2'b10;
          o_pcwrite = 1'b1;
        end
        S_BEQ: begin
          o_alusrca = 2'b10;
          aluop     = 2'b01;
          o_pcwrite = branch_taken;
        end
        S_FAULT: o_fault = 1'b1;
        default: ;
      endcase
    end

    // funct7b5 selects sub only for R-type (op[5] set); addi ignores it.
    o_alucrtl = ALUCTRL_W'(alu_decode(aluop, i_funct3, i_op[5] & i_funct7b5));
  end

endmodule
